decode_stage: RTL and testbench

Registered, parametrised instruction decode stage for the 16-bit Harvard processor. It accepts one fetched instruction word per cycle over a valid/ready handshake, splits it into opcode, register, memory-address and immediate fields with per-format zeroing, and presents the result to execute through a two-entry skid buffer. The buffer allows full throughput with a registered `in_ready`. An optional illegal-opcode trap stalls fetch until the core acknowledges it.

---
 rtl/decode_stage.sv | 178 +++++++++++++++++
 tb/tb_decode_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: splits a fetched word into per-format fields; optional trap via DECODE_ILLEGAL_TRAP_EN.
// Latency: one cycle from accept to out_valid; full throughput while out_ready is held high.
// Backpressure: two-entry skid buffer; registered in_ready drops the cycle after the skid entry fills.
module decode_stage #(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int REG_AW  = 5,
    parameter int MEM_AW  = 8,
    parameter int IMM_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPC_W-1:0]    opcode,
    output logic [2:0]          fmt,
    output logic [3:0]          alu_op,
    output logic [REG_AW-1:0]   rdst2,
    output logic [REG_AW-1:0]   rdst1,
    output logic [REG_AW-1:0]   rsrc2,
    output logic [REG_AW-1:0]   rsrc1,
    output logic [MEM_AW-1:0]   dst_addr,
    output logic [MEM_AW-1:0]   src_addr,
    output logic [IMM_W-1:0]    imm,
    output logic                illegal,
    input  logic                trap_ack
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TRAP = 1'b1;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [2:0]        fmt;
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] rdst2;
        logic [REG_AW-1:0] rdst1;
        logic [REG_AW-1:0] rsrc2;
        logic [REG_AW-1:0] rsrc1;
        logic [MEM_AW-1:0] dst_addr;
        logic [MEM_AW-1:0] src_addr;
        logic [IMM_W-1:0]  imm;
        logic              illegal;
    } dec_t;

    logic [OPC_W-1:0] opc;
    dec_t             dec;

    logic main_vld_q, main_vld_d;
    dec_t main_dat_q, main_dat_d;
    logic skid_vld_q, skid_vld_d;
    dec_t skid_dat_q, skid_dat_d;
    logic in_rdy_q, in_rdy_d;
    logic state_q, state_d;
    logic accept, consume;

    always_comb begin
        opc        = instr[INSTR_W-1 -: OPC_W];
        dec        = '0;
        dec.opcode = opc;
        if (opc == OPC_W'(0)) begin
            dec.fmt   = 3'd0;
            dec.rdst2 = instr[INSTR_W-OPC_W-1 -: REG_AW];
            dec.imm   = instr[IMM_W-1:0];
        end else if (opc == OPC_W'(1)) begin
            dec.fmt   = 3'd1;
            dec.rdst2 = instr[INSTR_W-OPC_W-1 -: REG_AW];
            dec.rsrc2 = instr[REG_AW-1:0];
        end else if (opc == OPC_W'(2)) begin
            dec.fmt      = 3'd2;
            dec.rdst2    = instr[INSTR_W-OPC_W-1 -: REG_AW];
            dec.src_addr = instr[MEM_AW-1:0];
        end else if (opc == OPC_W'(3)) begin
            dec.fmt      = 3'd3;
            dec.dst_addr = instr[INSTR_W-OPC_W-1 -: MEM_AW];
            dec.rsrc2    = instr[REG_AW-1:0];
        end else if (opc >= OPC_W'(4) && opc <= OPC_W'(16)) begin
            dec.fmt    = 3'd4;
            dec.alu_op = 4'(opc - OPC_W'(4));
            dec.rdst2  = instr[INSTR_W-OPC_W-1 -: REG_AW];
            dec.rdst1  = instr[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
            dec.rsrc2  = instr[2*REG_AW-1:REG_AW];
            dec.rsrc1  = instr[REG_AW-1:0];
        end else begin
            // Unknown opcode: all operand fields stay zero so execute sees a NOP shape.
            dec.fmt = 3'd7;
`ifdef DECODE_ILLEGAL_TRAP_EN
            dec.illegal = 1'b1;
`endif
        end
    end

    assign accept  = in_valid && in_rdy_q;
    assign consume = main_vld_q && out_ready;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || consume) begin
            // Skid is only ever occupied while in_ready is low, so no accept races it here.
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = accept;
                if (accept) begin
                    main_dat_d = dec;
                end
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_dat_d = dec;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_held;
    assign illegal_held = (main_vld_q && main_dat_q.illegal) || (skid_vld_q && skid_dat_q.illegal);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (accept && dec.illegal && !flush) state_d = ST_TRAP;
            ST_TRAP: if (trap_ack && !illegal_held) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end
`else
    logic unused_trap_ack;
    assign unused_trap_ack = trap_ack;
    assign state_d         = ST_RUN;
`endif

    assign in_rdy_d = !skid_vld_d && (state_d == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            in_rdy_q   <= 1'b1;
            state_q    <= ST_RUN;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            in_rdy_q   <= in_rdy_d;
            state_q    <= state_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = main_vld_q;
    assign opcode    = main_dat_q.opcode;
    assign fmt       = main_dat_q.fmt;
    assign alu_op    = main_dat_q.alu_op;
    assign rdst2     = main_dat_q.rdst2;
    assign rdst1     = main_dat_q.rdst1;
    assign rsrc2     = main_dat_q.rsrc2;
    assign rsrc1     = main_dat_q.rsrc1;
    assign dst_addr  = main_dat_q.dst_addr;
    assign src_addr  = main_dat_q.src_addr;
    assign imm       = main_dat_q.imm;
    assign illegal   = main_dat_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, skid buffering, flush and illegal-opcode handling.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, illegal, trap_ack;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [2:0]  fmt;
    logic [3:0]  alu_op;
    logic [4:0]  rdst2, rdst1, rsrc2, rsrc1;
    logic [7:0]  dst_addr, src_addr;
    logic [15:0] imm;
    logic [64:0] fields;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign fields = {opcode, fmt, alu_op, rdst2, rdst1, rsrc2, rsrc1, dst_addr, src_addr, imm};

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .fmt(fmt), .alu_op(alu_op),
        .rdst2(rdst2), .rdst1(rdst1), .rsrc2(rsrc2), .rsrc1(rsrc1),
        .dst_addr(dst_addr), .src_addr(src_addr), .imm(imm),
        .illegal(illegal), .trap_ack(trap_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        instr    = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; trap_ack = 1'b0; instr = '0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (fields !== 65'd0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_fields got=%h ill=%0b exp=0", fields, illegal); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_formats();
        out_ready = 1'b1;
        send(32'h10A20043);
        checks++; if (out_valid !== 1'b1 || fields !== {6'd4, 3'd4, 4'd0, 5'd5, 5'd2, 5'd2, 5'd3, 8'd0, 8'd0, 16'd0})
            begin failures++; $display("FAIL add got=%h v=%0b", fields, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_after_add got=%0b exp=0", out_valid); end
        send(32'h00A0BEEF);
        checks++; if (fields !== {6'd0, 3'd0, 4'd0, 5'd5, 5'd0, 5'd0, 5'd0, 8'd0, 8'd0, 16'hBEEF})
            begin failures++; $display("FAIL loadi got=%h", fields); end
        tick();
        send(32'h0F400007);
        checks++; if (fields !== {6'd3, 3'd3, 4'd0, 5'd0, 5'd0, 5'd7, 5'd0, 8'hD0, 8'd0, 16'd0})
            begin failures++; $display("FAIL store got=%h", fields); end
        tick();
        send(32'h04600009);
        checks++; if (fields !== {6'd1, 3'd1, 4'd0, 5'd3, 5'd0, 5'd9, 5'd0, 8'd0, 8'd0, 16'd0})
            begin failures++; $display("FAIL mov got=%h", fields); end
        tick();
        send(32'h08E01234);
        checks++; if (fields !== {6'd2, 3'd2, 4'd0, 5'd7, 5'd0, 5'd0, 5'd0, 8'd0, 8'h34, 16'd0})
            begin failures++; $display("FAIL load got=%h", fields); end
        tick();
        send(32'h40000000);
        checks++; if (fields !== {6'd16, 3'd4, 4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 8'd0, 8'd0, 16'd0})
            begin failures++; $display("FAIL shr got=%h", fields); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00A0AAAA; tick();
        instr = 32'h00A01111; tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_drop got=%0b exp=0", in_ready); end
        instr = 32'h00A02222; tick();
        checks++; if (out_valid !== 1'b1 || imm !== 16'hAAAA) begin failures++; $display("FAIL bp_hold got=%h v=%0b exp=aaaa", imm, out_valid); end
        out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b1 || imm !== 16'h1111 || in_ready !== 1'b1)
            begin failures++; $display("FAIL bp_second got=%h rdy=%0b exp=1111 rdy=1", imm, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || imm !== 16'h2222) begin failures++; $display("FAIL bp_third got=%h exp=2222", imm); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00A0AAAA; tick();
        instr = 32'h00A01111; tick();
        instr = 32'h00A03333; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL flush_full got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready); end
        send(32'h00A04444);
        in_valid = 1'b1; instr = 32'h00A05555; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_beats_accept got=%0b exp=0", out_valid); end
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_reappear got=%0b imm=%h exp=0", out_valid, imm); end
    endtask

    task automatic test_illegal();
`ifdef DECODE_ILLEGAL_TRAP_EN
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'hFC000000; tick();
        checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || fmt !== 3'd7 || in_ready !== 1'b0)
            begin failures++; $display("FAIL trap_enter got ill=%0b fmt=%0d rdy=%0b exp 1 7 0", illegal, fmt, in_ready); end
        instr = 32'h00A0BEEF; trap_ack = 1'b1; tick();
        checks++; if (in_ready !== 1'b0 || illegal !== 1'b1)
            begin failures++; $display("FAIL trap_early_ack got rdy=%0b ill=%0b exp 0 1", in_ready, illegal); end
        trap_ack = 1'b0; out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
            begin failures++; $display("FAIL trap_consumed got v=%0b rdy=%0b exp 0 0", out_valid, in_ready); end
        trap_ack = 1'b1; tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL trap_exit got rdy=%0b v=%0b exp 1 0", in_ready, out_valid); end
        trap_ack = 1'b0; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || imm !== 16'hBEEF || illegal !== 1'b0 || fmt !== 3'd0)
            begin failures++; $display("FAIL trap_resume got v=%0b imm=%h ill=%0b exp 1 beef 0", out_valid, imm, illegal); end
        tick();
`else
        out_ready = 1'b1;
        send(32'h44000000);
        checks++; if (fmt !== 3'd7 || fields[54:0] !== 55'd0 || illegal !== 1'b0)
            begin failures++; $display("FAIL nop_boundary got fmt=%0d low=%h ill=%0b exp 7 0 0", fmt, fields[54:0], illegal); end
        tick();
        in_valid = 1'b1; instr = 32'hFC000000; tick();
        checks++; if (out_valid !== 1'b1 || fmt !== 3'd7 || fields[54:0] !== 55'd0 || illegal !== 1'b0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL nop_decode got fmt=%0d low=%h ill=%0b rdy=%0b", fmt, fields[54:0], illegal, in_ready); end
        instr = 32'h00A0BEEF; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || fmt !== 3'd0 || imm !== 16'hBEEF || rdst2 !== 5'd5)
            begin failures++; $display("FAIL nop_then_loadi got v=%0b fmt=%0d imm=%h exp 1 0 beef", out_valid, fmt, imm); end
        tick();
`endif
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            instr    = 32'h00A00000 | 32'(i * 3 + 1);
            tick();
            checks++; if (out_valid !== 1'b1 || imm !== 16'(i * 3 + 1) || in_ready !== 1'b1)
                begin failures++; $display("FAIL b2b_%0d got v=%0b imm=%h rdy=%0b exp imm=%0h", i, out_valid, imm, in_ready, i * 3 + 1); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00A0AAAA; tick();
        instr = 32'h00A01111; tick();
        in_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || fields !== 65'd0)
            begin failures++; $display("FAIL mid_reset got v=%0b rdy=%0b f=%h exp 0 1 0", out_valid, in_ready, fields); end
        tick();
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
